vector_mem_sequencer: RTL and testbench

//  Sits between the datapath's load/store requests and the single-word data cache port.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/vector_mem_sequencer_lane_select.sv | 25 ++
 rtl/vector_mem_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word and the vector memory sequencer states.
package cpu_types_pkg;

   localparam int WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      SCALAR,
      VECTOR,
      DONE
   } vmseq_state_t;

endpackage

// File: rtl/vector_mem_sequencer_lane_select.sv
// lane_select: finds the lowest set mask bit strictly above idx_i.
// An idx_i of -1 yields the first active lane.
module lane_select #(
   parameter int THREADS = 4,
   parameter int IDX_W   = 2
) (
   input  logic [THREADS-1:0]      mask_i,
   input  logic signed [IDX_W:0]   idx_i,
   output logic [IDX_W-1:0]        nextIdx_o,
   output logic                    noneLeft_o
);

   // Scan from the top down so the lowest qualifying lane wins.
   always_comb begin
      nextIdx_o  = '0;
      noneLeft_o = 1'b1;
      for (int i = THREADS - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(idx_i))) begin
            nextIdx_o  = IDX_W'(i);
            noneLeft_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: drives the single-word cache port for scalar accesses and
// serialises vector accesses one active lane at a time, pulsing dhit once per request.
// Optional feature macro: VMSEQ_COALESCE_EN (vector loads reuse the previous lane's
// word when the address repeats, without touching the cache).
module vector_mem_sequencer
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int WORD_W  = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       readReq,
   input  logic                       writeReq,
   input  logic                       isVector,
   input  logic [THREADS-1:0]         mask,
   input  logic [WORD_W-1:0]          sdaddr,
   input  logic [WORD_W-1:0]          sdstore,
   input  logic [THREADS*WORD_W-1:0]  vdaddr,
   input  logic [THREADS*WORD_W-1:0]  vdstore,
   output logic [WORD_W-1:0]          sdload,
   output logic [THREADS*WORD_W-1:0]  vdload,
   output logic                       dhit,
   output logic                       dREN,
   output logic                       dWEN,
   output logic [WORD_W-1:0]          daddr,
   output logic [WORD_W-1:0]          dstore,
   input  logic [WORD_W-1:0]          dload,
   input  logic                       dwait
);

   localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

   vmseq_state_t               state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic                       opWrite_q, opWrite_d;
   logic [WORD_W-1:0]          sdload_q, sdload_d;
   logic [THREADS*WORD_W-1:0]  vdload_q, vdload_d;

   logic [IDX_W-1:0]           firstIdx, nextIdx;
   logic                       firstNone, nextNone;
   logic [WORD_W-1:0]          laneAddr, laneStore, laneWord;
   logic                       laneDone;
   logic                       coalesceHit;
   logic [WORD_W-1:0]          coalesceWord;

   lane_select #(.THREADS(THREADS), .IDX_W(IDX_W)) firstSel (
      .mask_i     (mask),
      .idx_i      ('1),
      .nextIdx_o  (firstIdx),
      .noneLeft_o (firstNone)
   );

   lane_select #(.THREADS(THREADS), .IDX_W(IDX_W)) nextSel (
      .mask_i     (mask),
      .idx_i      ({1'b0, idx_q}),
      .nextIdx_o  (nextIdx),
      .noneLeft_o (nextNone)
   );

   assign laneAddr  = vdaddr[int'(idx_q)*WORD_W +: WORD_W];
   assign laneStore = vdstore[int'(idx_q)*WORD_W +: WORD_W];
   assign laneWord  = coalesceHit ? coalesceWord : dload;

`ifdef VMSEQ_COALESCE_EN
   logic              prevValid_q;
   logic [WORD_W-1:0] prevAddr_q, prevWord_q;

   assign coalesceHit  = (state_q == VECTOR) && !opWrite_q && prevValid_q &&
                         (laneAddr == prevAddr_q);
   assign coalesceWord = prevWord_q;

   // Remember the last serviced load lane so a repeated address can skip the cache.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prevValid_q <= 1'b0;
         prevAddr_q  <= '0;
         prevWord_q  <= '0;
      end else if (state_q == IDLE) begin
         prevValid_q <= 1'b0;
      end else if ((state_q == VECTOR) && laneDone && !opWrite_q) begin
         prevValid_q <= 1'b1;
         prevAddr_q  <= laneAddr;
         prevWord_q  <= laneWord;
      end
   end
`else
   assign coalesceHit  = 1'b0;
   assign coalesceWord = '0;
`endif

   // State, lane index, latched operation and load results.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         opWrite_q <= 1'b0;
         sdload_q  <= '0;
         vdload_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         opWrite_q <= opWrite_d;
         sdload_q  <= sdload_d;
         vdload_q  <= vdload_d;
      end
   end

   // Next-state decode and cache port drive; the port is idle outside SCALAR/VECTOR.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      opWrite_d = opWrite_q;
      sdload_d  = sdload_q;
      vdload_d  = vdload_q;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      daddr     = '0;
      dstore    = '0;
      dhit      = 1'b0;
      laneDone  = 1'b0;
      case (state_q)
         IDLE: begin
            if (readReq || writeReq) begin
               opWrite_d = writeReq;
               if (!isVector) begin
                  state_d = SCALAR;
               end else if (!firstNone) begin
                  state_d = VECTOR;
                  idx_d   = firstIdx;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SCALAR: begin
            dREN   = !opWrite_q;
            dWEN   = opWrite_q;
            daddr  = sdaddr;
            dstore = sdstore;
            if (!dwait) begin
               if (!opWrite_q) begin
                  sdload_d = dload;
               end
               state_d = DONE;
            end
         end
         VECTOR: begin
            daddr  = laneAddr;
            dstore = laneStore;
            if (coalesceHit) begin
               laneDone = 1'b1;
            end else begin
               dREN = !opWrite_q;
               dWEN = opWrite_q;
               if (!dwait) begin
                  laneDone = 1'b1;
               end
            end
            if (laneDone) begin
               if (!opWrite_q) begin
                  vdload_d[int'(idx_q)*WORD_W +: WORD_W] = laneWord;
               end
               if (nextNone) begin
                  state_d = DONE;
               end else begin
                  idx_d = nextIdx;
               end
            end
         end
         DONE: begin
            dhit    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sdload = sdload_q;
   assign vdload = vdload_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: table of directed requests, a reset-abort
// sequence and randomized requests checked against a lane-level reference model.
module tb_vector_mem_sequencer;

   localparam int T = 4;
   localparam int W = 32;
`ifdef VMSEQ_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            readReq = 1'b0, writeReq = 1'b0, isVector = 1'b0;
   logic [T-1:0]    mask = '0;
   logic [W-1:0]    sdaddr = '0, sdstore = '0;
   logic [T*W-1:0]  vdaddr = '0, vdstore = '0;
   logic [W-1:0]    sdload;
   logic [T*W-1:0]  vdload;
   logic            dhit, dREN, dWEN;
   logic [W-1:0]    daddr, dstore;
   logic [W-1:0]    dload = '0;
   logic            dwait = 1'b0;

   vector_mem_sequencer #(.THREADS(T), .WORD_W(W)) dut (
      .CLK(CLK), .RST(RST), .readReq(readReq), .writeReq(writeReq), .isVector(isVector),
      .mask(mask), .sdaddr(sdaddr), .sdstore(sdstore), .vdaddr(vdaddr), .vdstore(vdstore),
      .sdload(sdload), .vdload(vdload), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } acc_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        vec;
      logic [3:0]  m;
      logic [31:0] base;
      logic [31:0] stride;
      int          waits;
      int          expLat;
      int          expAcc;
   } vec_t;

   acc_t        obsQ[$];
   acc_t        expQ[$];
   int          dhitCycles[$];
   int          cycleCnt = 0;
   int          stallCount = 0;
   int          waitCnt = 0;
   int          waitMode = 0;
   int          waitFixed = 0;
   int          waitProb = 0;
   logic [31:0] memOv [logic [31:0]];

   int          assertCount = 0;
   int          failCount = 0;
   int          reqStart, obsBase, dhitBase, stallBase;
   logic [31:0] sdM;
   logic [31:0] vdM [T];

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memOv.exists(a)) return memOv[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Cache model: supplies read data, chooses dwait, logs completed accesses and dhit pulses.
   always @(negedge CLK) begin
      cycleCnt++;
      dload = memRead(daddr);
      if (RST || !(dREN || dWEN)) begin
         dwait   = 1'b0;
         waitCnt = 0;
      end else if (waitMode == 1) begin
         dwait = ($urandom_range(99) < waitProb);
      end else if (waitCnt < waitFixed) begin
         dwait = 1'b1;
         waitCnt++;
      end else begin
         dwait   = 1'b0;
         waitCnt = 0;
      end
      if (!RST && (dREN || dWEN) && dwait) stallCount++;
      if (!RST && (dREN || dWEN) && !dwait)
         obsQ.push_back('{we: dWEN, addr: daddr, data: (dWEN ? dstore : 32'h0), cyc: cycleCnt});
      if (dhit) dhitCycles.push_back(cycleCnt);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: list of cache accesses and resulting load registers, lane by lane.
   function automatic int modelRequest(input logic rd, input logic wr, input logic vec,
                                       input logic [3:0] m, input logic [31:0] sa,
                                       input logic [31:0] ss, input logic [127:0] va,
                                       input logic [127:0] vs);
      int          coal = 0;
      logic        haveP = 1'b0;
      logic [31:0] pa = '0, a, d;
      expQ.delete();
      if (!rd && !wr) return 0;
      if (!vec) begin
         expQ.push_back('{we: wr, addr: sa, data: (wr ? ss : 32'h0), cyc: 0});
         if (!wr) sdM = memRead(sa);
         return 0;
      end
      for (int i = 0; i < T; i++) begin
         if (m[i]) begin
            a = va[i*32 +: 32];
            d = vs[i*32 +: 32];
            if (!wr && COALESCE && haveP && (a == pa)) coal++;
            else expQ.push_back('{we: wr, addr: a, data: (wr ? d : 32'h0), cyc: 0});
            if (!wr) begin
               vdM[i] = memRead(a);
               pa     = a;
               haveP  = 1'b1;
            end
         end
      end
      return coal;
   endfunction

   task automatic applyStimulus(input logic rd, input logic wr, input logic vec,
                                input logic [3:0] m, input logic [31:0] sa,
                                input logic [31:0] ss, input logic [127:0] va,
                                input logic [127:0] vs);
      @(posedge CLK);
      #1;
      obsBase   = obsQ.size();
      dhitBase  = dhitCycles.size();
      stallBase = stallCount;
      readReq = rd; writeReq = wr; isVector = vec; mask = m;
      sdaddr = sa; sdstore = ss; vdaddr = va; vdstore = vs;
      reqStart = cycleCnt;
      for (int k = 0; k < 400; k++) begin
         @(posedge CLK);
         if (dhitCycles.size() > dhitBase) break;
      end
      #1;
      readReq  = 1'b0;
      writeReq = 1'b0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic checkRequest(input string tag, input int expLat, input int nCoal);
      int lat, want, nObs;
      nObs = obsQ.size() - obsBase;
      lat  = (dhitCycles.size() > dhitBase) ? dhitCycles[dhitBase] - reqStart - 1 : -1;
      want = (expLat >= 0) ? expLat : 1 + expQ.size() + nCoal + (stallCount - stallBase);
      checkOutput({tag, ".latency"}, lat, want);
      checkOutput({tag, ".dhits"}, dhitCycles.size() - dhitBase, 1);
      checkOutput({tag, ".accesses"}, nObs, expQ.size());
      for (int i = 0; i < expQ.size() && i < nObs; i++)
         checkOutput($sformatf("%s.acc%0d", tag, i),
                     {obsQ[obsBase+i].we, obsQ[obsBase+i].addr, obsQ[obsBase+i].data},
                     {expQ[i].we, expQ[i].addr, expQ[i].data});
      checkOutput({tag, ".sdload"}, sdload, sdM);
      checkOutput({tag, ".vdload"}, vdload, {vdM[3], vdM[2], vdM[1], vdM[0]});
   endtask

   initial begin
      vec_t        tbl[7];
      logic [127:0] va, vs;
      logic [31:0]  ss, sa;
      int           coal, firstRel, r;

      sdM = '0;
      for (int i = 0; i < T; i++) vdM[i] = '0;
      memOv[32'h100] = 32'hCAFE;
      memOv[32'h40]  = 32'h7;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h0,  0, 2,  1};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 4'b1011, 32'h0,   32'h4,  2, 10, 3};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 4'b0000, 32'h600, 32'h4,  0, 1,  0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h200, 32'h0,  0, 2,  1};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 4'b1111, 32'h40,  32'h0,  0, 5,  (COALESCE ? 1 : 4)};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 4'b1111, 32'h80,  32'h0,  1, 9,  4};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 4'b0100, 32'h300, 32'h8,  0, 2,  1};

      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset.dhit", dhit, 0);
      checkOutput("reset.dREN", dREN, 0);
      checkOutput("reset.dWEN", dWEN, 0);
      checkOutput("reset.daddr", daddr, 0);
      checkOutput("reset.dstore", dstore, 0);
      checkOutput("reset.sdload", sdload, 0);
      checkOutput("reset.vdload", vdload, 0);
      RST = 1'b0;

      // Directed table
      for (int n = 0; n < 7; n++) begin
         for (int i = 0; i < T; i++) begin
            va[i*32 +: 32] = tbl[n].base + i * tbl[n].stride;
            vs[i*32 +: 32] = 32'h1000 * (i + 1) + n;
         end
         sa = tbl[n].base;
         ss = 32'h5000 + n;
         waitMode  = 0;
         waitFixed = tbl[n].waits;
         coal = modelRequest(tbl[n].rd, tbl[n].wr, tbl[n].vec, tbl[n].m, sa, ss, va, vs);
         applyStimulus(tbl[n].rd, tbl[n].wr, tbl[n].vec, tbl[n].m, sa, ss, va, vs);
         checkRequest($sformatf("tbl%0d", n), tbl[n].expLat, coal);
         checkOutput($sformatf("tbl%0d.accCount", n), obsQ.size() - obsBase, tbl[n].expAcc);
         if (tbl[n].expAcc > 0 && obsQ.size() > obsBase) begin
            firstRel = obsQ[obsBase].cyc - reqStart - 1;
            checkOutput($sformatf("tbl%0d.firstAccCycle", n), firstRel, 1 + tbl[n].waits);
         end
         if (n == 0) checkOutput("scalarLoad.sdload", sdload, 32'hCAFE);
         if (n == 1) checkOutput("vecLoad.lane2Kept", vdload[95:64], 32'h0);
         if (n == 3) checkOutput("rdwr.sdloadKept", sdload, 32'hCAFE);
         if (n == 4) checkOutput("sameAddr.vdload", vdload, {4{32'h7}});
      end

      // Reset while lane 1 of a four-lane load is waiting on the cache
      waitMode  = 0;
      waitFixed = 3;
      @(posedge CLK);
      #1;
      obsBase  = obsQ.size();
      dhitBase = dhitCycles.size();
      readReq = 1'b1; isVector = 1'b1; mask = 4'hF;
      for (int i = 0; i < T; i++) vdaddr[i*32 +: 32] = 32'h500 + 4 * i;
      for (int k = 0; k < 100 && (obsQ.size() - obsBase) < 1; k++) @(posedge CLK);
      #2;
      checkOutput("abort.lane1Addr", daddr, 32'h504);
      checkOutput("abort.lane1REN", dREN, 1);
      RST = 1'b1;
      #1;
      checkOutput("abort.dREN", dREN, 0);
      checkOutput("abort.daddr", daddr, 0);
      checkOutput("abort.dhit", dhit, 0);
      checkOutput("abort.vdload", vdload, 0);
      checkOutput("abort.sdload", sdload, 0);
      readReq = 1'b0; isVector = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      checkOutput("abort.noDhit", dhitCycles.size() - dhitBase, 0);
      sdM = '0;
      for (int i = 0; i < T; i++) vdM[i] = '0;
      waitFixed = 0;
      coal = modelRequest(1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, '0, '0);
      checkRequest("afterAbort", 2, coal);

      // Randomized requests with random cache stalls
      waitMode = 1;
      waitProb = 30;
      for (int n = 0; n < 40; n++) begin
         logic rd, wr, vec;
         logic [3:0] m;
         r   = $urandom_range(2);
         rd  = (r != 1);
         wr  = (r != 0);
         vec = ($urandom_range(3) != 0);
         m   = 4'($urandom_range(15));
         for (int i = 0; i < T; i++) begin
            if (i > 0 && $urandom_range(1) == 1) va[i*32 +: 32] = va[(i-1)*32 +: 32];
            else va[i*32 +: 32] = ($urandom_range(2) == 0) ? 32'h40 : ($urandom() & 32'hFFFF_FFFC);
            vs[i*32 +: 32] = $urandom();
         end
         sa = ($urandom_range(1) == 0) ? 32'h100 : ($urandom() & 32'hFFFF_FFFC);
         ss = $urandom();
         coal = modelRequest(rd, wr, vec, m, sa, ss, va, vs);
         applyStimulus(rd, wr, vec, m, sa, ss, va, vs);
         checkRequest($sformatf("rand%0d", n), -1, coal);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Absolute time limit so the run cannot hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
